axi_read_resp_router: RTL and testbench

- Return-path companion to the address-channel stream arbiter in the crossbar slave port.
- Records which master won each read-address grant (arbiter chosen index at AR fire) in an in-order FIFO.
- Routes the slave's R beats back to that master, one burst per entry, popping on the last beat.
- Sits between one slave R channel and three master R channels.

---
 rtl/axi_read_resp_router.sv | 160 ++++++++++++++++
 tb/tb_axi_read_resp_router.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_resp_router.sv
// Read-response router: remembers which master won each AR grant in an in-order
// FIFO and steers the slave R channel back to that master, one burst per entry.
module axi_read_resp_router #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    io_cmd_valid,
   output logic                    io_cmd_ready,
   input  logic [1:0]              io_cmd_chosen,

   input  logic                    io_rsp_valid,
   output logic                    io_rsp_ready,
   input  logic [DATA_WIDTH-1:0]   io_rsp_payload_data,
   input  logic [ID_WIDTH-1:0]     io_rsp_payload_id,
   input  logic [1:0]              io_rsp_payload_resp,
   input  logic                    io_rsp_payload_last,

   output logic                    io_outputs_0_valid,
   input  logic                    io_outputs_0_ready,
   output logic [DATA_WIDTH-1:0]   io_outputs_0_payload_data,
   output logic [ID_WIDTH-1:0]     io_outputs_0_payload_id,
   output logic [1:0]              io_outputs_0_payload_resp,
   output logic                    io_outputs_0_payload_last,

   output logic                    io_outputs_1_valid,
   input  logic                    io_outputs_1_ready,
   output logic [DATA_WIDTH-1:0]   io_outputs_1_payload_data,
   output logic [ID_WIDTH-1:0]     io_outputs_1_payload_id,
   output logic [1:0]              io_outputs_1_payload_resp,
   output logic                    io_outputs_1_payload_last,

   output logic                    io_outputs_2_valid,
   input  logic                    io_outputs_2_ready,
   output logic [DATA_WIDTH-1:0]   io_outputs_2_payload_data,
   output logic [ID_WIDTH-1:0]     io_outputs_2_payload_id,
   output logic [1:0]              io_outputs_2_payload_resp,
   output logic                    io_outputs_2_payload_last,

   output logic [$clog2(DEPTH):0]  io_pending,
   output logic                    io_error
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [CNT_W-1:0] wr_ptr;
   logic [CNT_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [1:0]       idx_mem [DEPTH];
   logic             error_q;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [1:0]       head;
   logic [2:0]       out_valid;
   logic             rsp_ready;
   logic             sink;
   logic             sink_fire;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = idx_mem[rd_ptr[PTR_W-1:0]];

   assign io_cmd_ready = !full;
   assign push         = io_cmd_valid && !full;

   // Steer valid to the head master; index 3 means nobody owns the burst, so sink it.
   always_comb begin
      out_valid = 3'b000;
      rsp_ready = 1'b0;
      sink      = 1'b0;
      if (!empty) begin
         case (head)
            2'd0: begin
               out_valid[0] = io_rsp_valid;
               rsp_ready    = io_outputs_0_ready;
            end
            2'd1: begin
               out_valid[1] = io_rsp_valid;
               rsp_ready    = io_outputs_1_ready;
            end
            2'd2: begin
               out_valid[2] = io_rsp_valid;
               rsp_ready    = io_outputs_2_ready;
            end
            default: begin
               rsp_ready = 1'b1;
               sink      = 1'b1;
            end
         endcase
      end
   end

   assign pop       = io_rsp_valid && rsp_ready && io_rsp_payload_last;
   assign sink_fire = io_rsp_valid && sink;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         error_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (sink_fire) begin
            error_q <= 1'b1;
         end
      end
   end

   // Index storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         idx_mem[wr_ptr[PTR_W-1:0]] <= io_cmd_chosen;
      end
   end

   assign io_rsp_ready = rsp_ready;
   assign io_pending   = count;
   assign io_error     = error_q;

   assign io_outputs_0_valid = out_valid[0];
   assign io_outputs_1_valid = out_valid[1];
   assign io_outputs_2_valid = out_valid[2];

   // Payload is broadcast unchanged; only valid is steered.
   assign io_outputs_0_payload_data = io_rsp_payload_data;
   assign io_outputs_0_payload_id   = io_rsp_payload_id;
   assign io_outputs_0_payload_resp = io_rsp_payload_resp;
   assign io_outputs_0_payload_last = io_rsp_payload_last;

   assign io_outputs_1_payload_data = io_rsp_payload_data;
   assign io_outputs_1_payload_id   = io_rsp_payload_id;
   assign io_outputs_1_payload_resp = io_rsp_payload_resp;
   assign io_outputs_1_payload_last = io_rsp_payload_last;

   assign io_outputs_2_payload_data = io_rsp_payload_data;
   assign io_outputs_2_payload_id   = io_rsp_payload_id;
   assign io_outputs_2_payload_resp = io_rsp_payload_resp;
   assign io_outputs_2_payload_last = io_rsp_payload_last;

endmodule

// File: tb/tb_axi_read_resp_router.sv
// Bench for axi_read_resp_router: directed stimulus pushes expected beats into a
// scoreboard queue; a negedge monitor pops and compares every delivered or sunk beat.
module tb_axi_read_resp_router;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned IW    = 4;
   localparam int unsigned PW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [1:0]    master;
      logic [DW-1:0] data;
      logic [IW-1:0] id;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   logic          clk;
   logic          reset;
   logic          io_cmd_valid;
   logic          io_cmd_ready;
   logic [1:0]    io_cmd_chosen;
   logic          io_rsp_valid;
   logic          io_rsp_ready;
   logic [DW-1:0] io_rsp_payload_data;
   logic [IW-1:0] io_rsp_payload_id;
   logic [1:0]    io_rsp_payload_resp;
   logic          io_rsp_payload_last;
   logic          o0_valid, o1_valid, o2_valid;
   logic          o0_ready, o1_ready, o2_ready;
   logic [DW-1:0] o0_data, o1_data, o2_data;
   logic [IW-1:0] o0_id, o1_id, o2_id;
   logic [1:0]    o0_resp, o1_resp, o2_resp;
   logic          o0_last, o1_last, o2_last;
   logic [PW-1:0] io_pending;
   logic          io_error;

   beat_t exp_q[$];
   int    checks;
   int    errors;

   axi_read_resp_router #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .io_cmd_valid              (io_cmd_valid),
      .io_cmd_ready              (io_cmd_ready),
      .io_cmd_chosen             (io_cmd_chosen),
      .io_rsp_valid              (io_rsp_valid),
      .io_rsp_ready              (io_rsp_ready),
      .io_rsp_payload_data       (io_rsp_payload_data),
      .io_rsp_payload_id         (io_rsp_payload_id),
      .io_rsp_payload_resp       (io_rsp_payload_resp),
      .io_rsp_payload_last       (io_rsp_payload_last),
      .io_outputs_0_valid        (o0_valid),
      .io_outputs_0_ready        (o0_ready),
      .io_outputs_0_payload_data (o0_data),
      .io_outputs_0_payload_id   (o0_id),
      .io_outputs_0_payload_resp (o0_resp),
      .io_outputs_0_payload_last (o0_last),
      .io_outputs_1_valid        (o1_valid),
      .io_outputs_1_ready        (o1_ready),
      .io_outputs_1_payload_data (o1_data),
      .io_outputs_1_payload_id   (o1_id),
      .io_outputs_1_payload_resp (o1_resp),
      .io_outputs_1_payload_last (o1_last),
      .io_outputs_2_valid        (o2_valid),
      .io_outputs_2_ready        (o2_ready),
      .io_outputs_2_payload_data (o2_data),
      .io_outputs_2_payload_id   (o2_id),
      .io_outputs_2_payload_resp (o2_resp),
      .io_outputs_2_payload_last (o2_last),
      .io_pending                (io_pending),
      .io_error                  (io_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic record(input logic [1:0] m, input logic [DW-1:0] d, input logic [IW-1:0] id,
                         input logic [1:0] r, input logic l);
      beat_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_beat: got master %0d data 0x%0h expected none", m, d);
      end else begin
         e = exp_q.pop_front();
         check("beat_master", 32'(m), 32'(e.master));
         check("beat_data", d, e.data);
         check("beat_id", 32'(id), 32'(e.id));
         check("beat_resp", 32'(r), 32'(e.resp));
         check("beat_last", 32'(l), 32'(e.last));
      end
   endtask

   // Monitor: a beat fires at the next posedge when valid and ready are both high here.
   always @(negedge clk) begin : monitor
      logic [2:0] vld;
      if (reset) begin
         vld = {o2_valid, o1_valid, o0_valid};
         if (vld != 3'b000) begin
            check("valid_onehot", 32'($countones(vld)), 32'd1);
            check("valid_needs_slave", 32'(io_rsp_valid), 32'd1);
         end
         if (o0_valid && o0_ready) record(2'd0, o0_data, o0_id, o0_resp, o0_last);
         if (o1_valid && o1_ready) record(2'd1, o1_data, o1_id, o1_resp, o1_last);
         if (o2_valid && o2_ready) record(2'd2, o2_data, o2_id, o2_resp, o2_last);
         if (io_rsp_valid && io_rsp_ready && vld == 3'b000)
            record(2'd3, io_rsp_payload_data, io_rsp_payload_id, io_rsp_payload_resp,
                   io_rsp_payload_last);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] ch);
      io_cmd_valid  = 1'b1;
      io_cmd_chosen = ch;
      step();
      io_cmd_valid  = 1'b0;
   endtask

   // Drive one beat and hold it until the router accepts it; stalls counts refused cycles.
   task automatic send_beat(input logic [1:0] m, input logic [DW-1:0] d, input logic l,
                            output int stalls);
      exp_q.push_back(beat_t'{m, d, IW'(d), 2'(d >> 4), l});
      io_rsp_valid        = 1'b1;
      io_rsp_payload_data = d;
      io_rsp_payload_id   = IW'(d);
      io_rsp_payload_resp = 2'(d >> 4);
      io_rsp_payload_last = l;
      stalls = 0;
      #1;
      while (!io_rsp_ready && stalls < 50) begin
         stalls++;
         step();
         #1;
      end
      check("rsp_ready_timeout", 32'(io_rsp_ready), 32'd1);
      step();
      io_rsp_valid        = 1'b0;
      io_rsp_payload_last = 1'b0;
   endtask

   task automatic send_burst(input logic [1:0] m, input logic [DW-1:0] base, input int len,
                             output int stalls);
      int s;
      stalls = 0;
      for (int i = 0; i < len; i++) begin
         send_beat(m, base + DW'(i), (i == len - 1), s);
         stalls += s;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int st;
      int st_b;
      checks = 0;
      errors = 0;
      reset = 1'b0;
      io_cmd_valid = 1'b0;
      io_cmd_chosen = 2'd0;
      io_rsp_valid = 1'b1;
      io_rsp_payload_data = '0;
      io_rsp_payload_id = '0;
      io_rsp_payload_resp = 2'd0;
      io_rsp_payload_last = 1'b0;
      o0_ready = 1'b1;
      o1_ready = 1'b1;
      o2_ready = 1'b1;

      // Reset then idle, with slave valid held high
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst_cmd_ready", 32'(io_cmd_ready), 32'd1);
      check("rst_pending", 32'(io_pending), 32'd0);
      check("rst_valids", 32'({o2_valid, o1_valid, o0_valid}), 32'd0);
      check("rst_rsp_ready", 32'(io_rsp_ready), 32'd0);
      check("rst_error", 32'(io_error), 32'd0);
      step();
      check("idle_rsp_ready", 32'(io_rsp_ready), 32'd0);
      io_rsp_valid = 1'b0;

      // Single 4-beat burst to master 1
      push(2'd1);
      check("single_pending_after_push", 32'(io_pending), 32'd1);
      for (int i = 0; i < 3; i++) begin
         send_beat(2'd1, 32'hA0 + 32'(i), 1'b0, st);
         check("single_no_stall", 32'(st), 32'd0);
      end
      check("single_pending_midburst", 32'(io_pending), 32'd1);
      send_beat(2'd1, 32'hA3, 1'b1, st);
      check("single_pending_done", 32'(io_pending), 32'd0);

      // Ordering 2,0,2 with backpressure on master 2
      push(2'd2);
      push(2'd0);
      push(2'd2);
      check("order_pending", 32'(io_pending), 32'd3);
      o2_ready = 1'b0;
      fork
         send_burst(2'd2, 32'hB0, 2, st_b);
         begin
            step();
            step();
            step();
            o2_ready = 1'b1;
         end
      join
      check("order_stall_cycles", 32'(st_b), 32'd3);
      send_burst(2'd0, 32'hC0, 1, st);
      send_burst(2'd2, 32'hD0, 3, st);
      check("order_pending_done", 32'(io_pending), 32'd0);

      // Fill the FIFO, then attempt pushes while full
      io_cmd_valid = 1'b1;
      io_cmd_chosen = 2'd0; step();
      io_cmd_chosen = 2'd1; step();
      io_cmd_chosen = 2'd2; step();
      io_cmd_chosen = 2'd0; step();
      io_cmd_valid = 1'b0;
      check("full_pending", 32'(io_pending), 32'd4);
      check("full_cmd_ready", 32'(io_cmd_ready), 32'd0);
      push(2'd1);
      check("full_fifth_ignored", 32'(io_pending), 32'd4);
      io_cmd_valid = 1'b1;
      io_cmd_chosen = 2'd2;
      check("full_ready_during_pop", 32'(io_cmd_ready), 32'd0);
      send_beat(2'd0, 32'hE0, 1'b1, st);
      io_cmd_valid = 1'b0;
      check("full_pop_rejects_push", 32'(io_pending), 32'd3);
      check("full_ready_after_pop", 32'(io_cmd_ready), 32'd1);
      send_beat(2'd1, 32'hE1, 1'b1, st);
      send_beat(2'd2, 32'hE2, 1'b1, st);
      send_beat(2'd0, 32'hE3, 1'b1, st);
      check("full_drained", 32'(io_pending), 32'd0);

      // Simultaneous push and pop at pending=2
      push(2'd1);
      push(2'd2);
      check("sim_pending_before", 32'(io_pending), 32'd2);
      send_beat(2'd1, 32'hF0, 1'b0, st);
      io_cmd_valid = 1'b1;
      io_cmd_chosen = 2'd0;
      send_beat(2'd1, 32'hF1, 1'b1, st);
      io_cmd_valid = 1'b0;
      check("sim_pending_same", 32'(io_pending), 32'd2);
      send_beat(2'd2, 32'hF2, 1'b1, st);
      send_beat(2'd0, 32'hF3, 1'b1, st);
      check("sim_pending_done", 32'(io_pending), 32'd0);

      // Illegal index 3: beats are sunk and the error flag sticks
      check("err_clear_before", 32'(io_error), 32'd0);
      push(2'd3);
      send_beat(2'd3, 32'h50, 1'b0, st);
      check("err_sink_no_stall", 32'(st), 32'd0);
      check("err_set_first_beat", 32'(io_error), 32'd1);
      send_beat(2'd3, 32'h51, 1'b1, st);
      check("err_sticky", 32'(io_error), 32'd1);
      push(2'd0);
      send_beat(2'd0, 32'h60, 1'b1, st);
      check("err_after_normal", 32'(io_error), 32'd1);
      check("err_pending_done", 32'(io_pending), 32'd0);

      step();
      step();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
